// File: rtl/muldiv_pkg.sv
// muldiv_pkg
//   Shared encodings for the iterative multiply/divide unit.
//   - state_e : sequencer states (IDLE, CALC, FIXUP, DONE, DZERO)
//   - OP_MULT / OP_DIV : values of the op input
package muldiv_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CALC  = 3'd1,
    FIXUP = 3'd2,
    DONE  = 3'd3,
    DZERO = 3'd4
  } state_e;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/muldiv_iter_cnt.sv
// muldiv_iter_cnt
//   Loadable down-counter that paces the CALC phase of muldiv_seq.
//   Ports:
//     clk        in   clock
//     reset      in   asynchronous active-high reset (count -> 0)
//     load_i     in   load load_val_i (has priority over dec_i)
//     dec_i      in   decrement by one (saturates at 0)
//     load_val_i in   CNT_W value to load
//     last_o     out  high while count == 1 (final iteration)
module muldiv_iter_cnt #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             last_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign last_o = (count_q == CNT_W'(1));

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq
//   Iterative signed multiply/divide unit with its own sequencer.
//   Multiply is shift-add on magnitudes, divide is restoring division on
//   magnitudes; one bit per cycle, followed by a sign-fixup cycle.
//   Latency: start accepted in cycle 0, CALC cycles 1..WIDTH, FIXUP in
//   cycle WIDTH+1, done pulse in cycle WIDTH+2. Divide by zero reports
//   done+div_zero in cycle 1 and leaves hi/lo untouched.
//   Ports:
//     clk, reset      clock, asynchronous active-high reset
//     start           one-cycle request, sampled only in IDLE
//     op              0 = mult, 1 = div
//     a, b            operands (rs, rt), sampled with start
//     is_unsigned     (only with MULDIV_UNSIGNED_EN) unsigned operation
//     busy            high in CALC and FIXUP
//     done            one-cycle completion pulse
//     div_zero        one-cycle pulse with done on divide by zero
//     hi, lo          mult: product high/low; div: remainder/quotient
//   Optional build macro: MULDIV_UNSIGNED_EN adds the is_unsigned input,
//   which bypasses magnitude capture and sign fixup (multu/divu).
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MULDIV_UNSIGNED_EN
  input  logic             is_unsigned,
`endif
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e             state_q;
  logic               busy_q, done_q, dz_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q;      // mult: |a| addend; div: |b| divisor
  logic               op_q, neg_a_q, neg_b_q;

  // ---------------- operand conditioning ----------------
  logic             signed_op;
`ifdef MULDIV_UNSIGNED_EN
  assign signed_op = ~is_unsigned;
`else
  assign signed_op = 1'b1;
`endif

  logic             neg_a, neg_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  assign neg_a = signed_op & a[WIDTH-1];
  assign neg_b = signed_op & b[WIDTH-1];
  // Magnitude of the most negative value wraps to itself, which is the
  // correct unsigned magnitude 2^(WIDTH-1).
  assign mag_a = neg_a ? -a : a;
  assign mag_b = neg_b ? -b : b;

  logic accept, is_dz;
  assign accept = (state_q == IDLE) && start;
  assign is_dz  = (op == OP_DIV) && (b == '0);

  // ---------------- iteration counter ----------------
  logic cnt_last;
  muldiv_iter_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (accept && !is_dz),
    .dec_i      (state_q == CALC),
    .load_val_i (CNT_W'(WIDTH)),
    .last_o     (cnt_last)
  );

  // ---------------- one iteration of the datapath ----------------
  // acc_q = {upper, lower}. Mult: upper is the running partial product,
  // lower holds the unconsumed multiplier bits. Div: upper is the partial
  // remainder, lower shifts out dividend bits and shifts in quotient bits.
  logic [WIDTH-1:0]   mult_addend;
  logic [WIDTH:0]     mult_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_raw, rem_raw, quo_fix, rem_fix;

  always_comb begin
    mult_addend = acc_q[0] ? opnd_q : '0;
    mult_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mult_addend};
    div_shift   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff    = div_shift - {1'b0, opnd_q};
    if (op_q == OP_MULT) begin
      acc_d = {mult_sum, acc_q[WIDTH-1:1]};
    end else if (!div_diff[WIDTH]) begin
      // Partial remainder >= divisor: subtract and emit a 1.
      acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end

    quo_raw  = acc_q[WIDTH-1:0];
    rem_raw  = acc_q[2*WIDTH-1:WIDTH];
    prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    quo_fix  = (neg_a_q ^ neg_b_q) ? -quo_raw : quo_raw;
    // Remainder follows the dividend's sign (truncating division).
    rem_fix  = neg_a_q ? -rem_raw : rem_raw;
  end

  // ---------------- sequencer ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      op_q    <= OP_MULT;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (is_dz) begin
              state_q <= DZERO;
              done_q  <= 1'b1;
              dz_q    <= 1'b1;
            end else begin
              state_q <= CALC;
              busy_q  <= 1'b1;
              op_q    <= op;
              neg_a_q <= neg_a;
              neg_b_q <= neg_b;
              opnd_q  <= (op == OP_DIV) ? mag_b : mag_a;
              acc_q   <= {{WIDTH{1'b0}}, ((op == OP_DIV) ? mag_a : mag_b)};
            end
          end
        end
        CALC: begin
          acc_q <= acc_d;
          if (cnt_last) state_q <= FIXUP;
        end
        FIXUP: begin
          if (op_q == OP_DIV) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        DZERO:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative signed multiply/divide unit with its own sequencer. Replaces the fixed MULT_LOAD/CALC/RESULT and DIV_LOAD/CALC/RESULT handling in the main control FSM.
- Main control issues a one-cycle start, then waits on done. It then writes HI/LO and, on div_zero, takes the DIVZERO exception path.
- Operand width is parametrised.

Parameters:
- WIDTH, 32, operand width. hi and lo are WIDTH bits each. Legal values are 8 to 64.
- CNT_W, $clog2(WIDTH+1), width of the iteration counter. Derived; never overridden.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request. Sampled only in IDLE.
- op  in  1  0 = mult, 1 = div
- a  in  WIDTH  multiplicand/dividend (rs). Sampled with start.
- b  in  WIDTH  multiplier/divisor (rt). Sampled with start.
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse: result valid, or divide-by-zero flagged
- div_zero  out  1  one-cycle pulse with done when op=div and b=0
- hi  out  WIDTH  mult: upper product. div: remainder. Registered.
- lo  out  WIDTH  mult: lower product. div: quotient. Registered.

Behaviour:
- Reset (asynchronous): state=IDLE; busy, done, div_zero, hi, lo and counter all 0.
- States are IDLE, CALC, FIXUP, DONE and DZERO.
- IDLE, start=1, op=div, b=0: go to DZERO. Operands are not captured.
- IDLE, start=1, otherwise:
  - Capture |a|, |b| and the sign flags into internal registers.
  - Load counter=WIDTH and go to CALC.
  - The accepting cycle is cycle 0.
- CALC, mult: shift-add on magnitudes. One bit per cycle, 2*WIDTH accumulator.
- CALC, div: restoring division on magnitudes. One quotient bit per cycle.
- CALC counter: decrements each cycle. Leave CALC when it reaches 1, so CALC occupies cycles 1..WIDTH.
- FIXUP (cycle WIDTH+1):
  - mult: negate the 2*WIDTH product if sign(a)!=sign(b).
  - div: negate the quotient if signs differ; the remainder takes the sign of a.
  - Results are loaded into hi/lo.
- DONE (cycle WIDTH+2): done=1 and busy=0. Next state IDLE.
- DZERO (cycle 1): done=1 and div_zero=1. hi/lo keep their previous values. Next state IDLE.
- busy=1 in CALC and FIXUP only.
- hi/lo hold their value until the next FIXUP. The next start does not clear them.
- start while busy, or in DONE/DZERO: ignored. No queueing.
- A back-to-back start in the cycle after done is accepted, since state is IDLE by then.
- Arithmetic: WIDTH-bit two's complement; all negations wrap.
- Boundary cases:
  - div of the most negative value by -1: lo = most negative value (wrapped), hi=0, no flag.
  - mult of the most negative value by itself: hi=0x40000000, lo=0 (WIDTH=32).
  - a=0: normal full-latency completion.
- Reset mid-operation returns to IDLE immediately. No done is issued and hi/lo clear to 0.

Optional Feature:
- Macro: MULDIV_UNSIGNED_EN.
- Defined:
  - Adds input port is_unsigned (1 bit), sampled with start.
  - When it is 1, magnitude capture and FIXUP sign correction are bypassed. This gives MIPS multu/divu semantics.
  - Latency is unchanged.
  - div_zero still applies.
- Undefined: the port is absent and all operations are signed.

Decomposition:
- Package muldiv_pkg holds:
  - state encoding: IDLE=3'd0, CALC=3'd1, FIXUP=3'd2, DONE=3'd3, DZERO=3'd4
  - op encoding: OP_MULT=1'b0, OP_DIV=1'b1
- Sub-module muldiv_iter_cnt:
  - parametrised down-counter: load, decrement and a last flag (count==1).
  - Instantiated once.
- Datapath, magnitude/sign logic and FSM stay in muldiv_seq.

Test Plan (all at WIDTH=32):
- mult, a=7, b=0xFFFFFFFD (-3): done in cycle 34, hi=0xFFFFFFFF, lo=0xFFFFFFEB. busy high cycles 1..33.
- div, a=0xFFFFFFF9 (-7), b=2: lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1), done in cycle 34.
- Preload hi/lo with mult 3*5 (lo=15). Then div with b=0: done=div_zero=1 in cycle 1, busy never asserted, hi=0, lo=15 unchanged.
- div, a=0x80000000, b=0xFFFFFFFF: lo=0x80000000, hi=0, div_zero=0.
- Start pulsed again in cycle 10 of an active mult: ignored, first result correct. Then reset asserted in cycle 5 of a new op: next edge gives IDLE, busy=0, hi=lo=0, no done.
- With MULDIV_UNSIGNED_EN, is_unsigned=1, mult 0xFFFFFFFF*2: hi=1, lo=0xFFFFFFFE. Same operands signed: hi=0xFFFFFFFF, lo=0xFFFFFFFE.
